mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/tsc_mem_pkg.sv | 19 +
 rtl/arb_latency_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_mem_pkg.sv
// Shared types for the memory port arbiter.
// State, owner encoding and default sizes.
package tsc_mem_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/arb_latency_counter.sv
// Latency down-counter for the memory port arbiter.
// Loads a start value, counts down to zero, flags zero.
module arb_latency_counter
  import tsc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port.
// Data has priority; fetch is forced in after a burst of data grants.
module mem_port_arbiter
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MEM_LATENCY - 1);

  state_e        state;
  owner_e        owner;
  logic [SW-1:0] starve_cnt;
  logic          gnt_d;
  logic          gnt_i;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;

  // Grant decision for the current IDLE cycle.
  always_comb begin
    gnt_d    = d_req && !(i_req && (starve_cnt == S_MAX));
    gnt_i    = i_req && !gnt_d;
    cnt_load = (state == IDLE) && (i_req || d_req);
    cnt_dec  = (state == ACCESS) && !cnt_zero;
  end

  arb_latency_counter u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_data     <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_d) begin
            owner     <= OWN_D;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
            if (!i_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != S_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (gnt_i) begin
            owner      <= OWN_I;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            mem_req    <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCESS;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (owner == OWN_I) begin
              i_data  <= mem_rdata;
              i_ready <= 1'b1;
            end else begin
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
              d_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Vector table, directed corner cases, random vs timeline model.
module tb_mem_port_arbiter;

  localparam int W     = 16;
  localparam int LAT   = 2;
  localparam int LIMIT = 4;
  localparam logic [W-1:0] MK = 16'hA5A5;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic [W-1:0] i_data;
  logic         i_ready;
  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic [W-1:0] d_rdata;
  logic         d_ready;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         busy;

  logic         force_en;
  logic [W-1:0] force_val;

  int checks = 0;
  int errors = 0;

  assign mem_rdata = force_en ? force_val : (mem_addr ^ MK);

  mem_port_arbiter #(
    .WORD_SIZE    (W),
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_d;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rd;
    logic [W-1:0] exp_i;
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    int rdy_at;
    int acc;
    rdy_at = 0;
    acc = 0;
    force_en = 1'b1;
    force_val = v.rd;
    if (v.is_d) begin
      d_req = 1'b1;
      d_we = v.we;
      d_addr = v.addr;
      d_wdata = v.wdata;
    end else begin
      i_req = 1'b1;
      i_addr = v.addr;
    end
    for (int n = 1; n <= 20 && rdy_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        i_addr = 16'($urandom);
        d_addr = 16'($urandom);
        d_wdata = 16'($urandom);
        d_we = ~d_we;
      end
      chk("ready_excl", {31'd0, i_ready & d_ready}, 0);
      chk("other_ready", {31'd0, v.is_d ? i_ready : d_ready}, 0);
      if (mem_req) begin
        acc++;
        chk("acc_addr", {16'd0, mem_addr}, {16'd0, v.addr});
        chk("acc_we", {31'd0, mem_we}, {31'd0, v.is_d & v.we});
        if (v.is_d && v.we)
          chk("acc_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
      end
      if (v.is_d ? d_ready : i_ready) rdy_at = n;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("latency", rdy_at, LAT + 1);
    chk("acc_cycles", acc, LAT);
    chk("i_data", {16'd0, i_data}, {16'd0, v.exp_i});
    chk("d_rdata", {16'd0, d_rdata}, {16'd0, v.exp_d});
    @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_mem_req", {31'd0, mem_req}, 0);
    force_en = 1'b0;
  endtask

  int t, g, s, d_at, i_at, nrdy, ngnt;
  logic active, own_d, m_we, prev_req, in_acc, in_resp;
  logic [W-1:0] m_addr, m_wdata, exp_i, exp_d;
  logic own_log [10];

  initial begin
    force_en = 1'b0;
    force_val = '0;
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    i_addr = '0;
    d_addr = '0;
    d_wdata = '0;

    tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 16'hA5A5, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1357, 16'hA5A5, 16'h1357};
    tbl[2] = '{1'b1, 1'b1, 16'h0300, 16'h1234, 16'hDEAD, 16'hA5A5, 16'h1357};
    tbl[3] = '{1'b0, 1'b0, 16'h0FFE, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h1357};
    tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001};
    tbl[5] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h7777, 16'hFFFF, 16'h0001};

    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_readys", {30'd0, i_ready, d_ready}, 0);
    chk("rst_addr", {mem_addr, mem_wdata}, 0);
    chk("rst_data", {i_data, d_rdata}, 0);

    do_reset();
    for (int k = 0; k < 6; k++) run_txn(tbl[k]);

    // Simultaneous requests: data first, then fetch.
    i_req = 1'b1;
    i_addr = 16'h0040;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 16'h0200;
    d_at = 0;
    i_at = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      chk("sim_excl", {31'd0, i_ready & d_ready}, 0);
      if (d_ready) begin
        d_at = n;
        d_req = 1'b0;
      end
      if (i_ready) begin
        i_at = n;
        i_req = 1'b0;
      end
    end
    chk("sim_d_at", d_at, 3);
    chk("sim_i_at", i_at, 7);
    chk("sim_d_rdata", {16'd0, d_rdata}, {16'd0, 16'h0200 ^ MK});
    chk("sim_i_data", {16'd0, i_data}, {16'd0, 16'h0040 ^ MK});

    // Reset during the second ACCESS cycle.
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 16'h0555;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_req", {31'd0, mem_req}, 1);
    reset = 1'b1;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 0);
    chk("async_busy", {31'd0, busy}, 0);
    chk("async_data", {i_data, d_rdata}, 0);
    d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_no_ready", {30'd0, i_ready, d_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    d_req = 1'b1;
    d_addr = 16'h0666;
    d_at = 0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) chk("post_rst_grant", {31'd0, mem_req}, 1);
      if (d_ready) begin
        d_at = n;
        d_req = 1'b0;
      end
    end
    chk("post_rst_lat", d_at, LAT + 1);
    chk("post_rst_data", {16'd0, d_rdata}, {16'd0, 16'h0666 ^ MK});

    // Requester drops d_req during ACCESS.
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 16'h0777;
    d_wdata = 16'hBEEF;
    nrdy = 0;
    ngnt = 0;
    d_at = 0;
    prev_req = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) d_req = 1'b0;
      if (mem_req && !prev_req) ngnt++;
      prev_req = mem_req;
      if (d_ready) begin
        nrdy++;
        d_at = n;
      end
    end
    chk("drop_grants", ngnt, 1);
    chk("drop_readys", nrdy, 1);
    chk("drop_ready_at", d_at, LAT + 1);
    chk("drop_d_rdata", {16'd0, d_rdata}, {16'd0, 16'h0666 ^ MK});

    // Starvation: both held high continuously.
    do_reset();
    i_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    nrdy = 0;
    for (int n = 0; n < 80 && nrdy < 10; n++) begin
      @(posedge clk);
      #1;
      if (i_ready || d_ready) begin
        own_log[nrdy] = d_ready;
        nrdy++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("starve_count", nrdy, 10);
    for (int k = 0; k < nrdy; k++)
      chk("starve_owner", {31'd0, own_log[k]}, {31'd0, (k % 5) != 4});
    repeat (6) @(posedge clk);
    #1;

    // Random traffic against a transaction timeline model.
    do_reset();
    t = 0;
    g = 0;
    s = 0;
    active = 1'b0;
    own_d = 1'b0;
    m_we = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    exp_i = '0;
    exp_d = '0;
    for (int k = 0; k < 1500; k++) begin
      in_acc = active && (t >= g + 1) && (t <= g + LAT);
      in_resp = active && (t == g + LAT + 1);
      if (in_resp) begin
        if (!own_d) exp_i = m_addr ^ MK;
        else if (!m_we) exp_d = m_addr ^ MK;
      end
      chk("r_mem_req", {31'd0, mem_req}, {31'd0, in_acc});
      chk("r_busy", {31'd0, busy}, {31'd0, in_acc | in_resp});
      chk("r_i_ready", {31'd0, i_ready}, {31'd0, in_resp & !own_d});
      chk("r_d_ready", {31'd0, d_ready}, {31'd0, in_resp & own_d});
      chk("r_i_data", {16'd0, i_data}, {16'd0, exp_i});
      chk("r_d_rdata", {16'd0, d_rdata}, {16'd0, exp_d});
      if (in_acc) begin
        chk("r_mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
        chk("r_mem_we", {31'd0, mem_we}, {31'd0, m_we});
        if (m_we) chk("r_mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
      end
      if (i_ready) begin
        i_req = 1'b0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = 16'($urandom);
      end
      if (d_ready) begin
        d_req = 1'b0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom);
        d_wdata = 16'($urandom);
      end
      if (!active || t >= g + LAT + 2) begin
        active = 1'b0;
        if (!i_req) s = 0;
        if (d_req && !(i_req && s == LIMIT)) begin
          if (i_req && s < LIMIT) s++;
          own_d = 1'b1;
          m_we = d_we;
          m_addr = d_addr;
          m_wdata = d_wdata;
          g = t;
          active = 1'b1;
        end else if (i_req) begin
          s = 0;
          own_d = 1'b0;
          m_we = 1'b0;
          m_addr = i_addr;
          m_wdata = '0;
          g = t;
          active = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      t++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
